// File: rtl/pc_btb_unit_pkg.sv
// pc_btb_unit_pkg
//   Shared constants and helpers for the fetch PC / BTB block.
//   - ADDR_W_DEF / START_ADDR_DEF : default memory width and reset PC
//   - CTR_MAX_W                   : widest direction counter the helpers handle
//   - weak_taken(width)           : weakly-taken counter init (MSB set, rest 0)
//   - sat_inc_dec(ctr, up, width) : saturating +1/-1 within [0, 2^width-1]
package pc_btb_unit_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int START_ADDR_DEF = 0;
    localparam int CTR_MAX_W      = 16;

    localparam int CTR_W_DEF = 2;

    function automatic logic [CTR_MAX_W-1:0] weak_taken(input int unsigned width);
        return CTR_MAX_W'(1) << (width - 1);
    endfunction

    localparam logic [CTR_MAX_W-1:0] WEAK_TAKEN_DEF = weak_taken(CTR_W_DEF);

    function automatic logic [CTR_MAX_W-1:0] sat_inc_dec(input logic [CTR_MAX_W-1:0] ctr,
                                                         input logic                 up,
                                                         input int unsigned          width);
        logic [CTR_MAX_W-1:0] max_v;
        // At width == CTR_MAX_W the shift wraps to 0 and the -1 yields all ones.
        max_v = (CTR_MAX_W'(1) << width) - CTR_MAX_W'(1);
        if (up) return (ctr == max_v) ? ctr : ctr + CTR_MAX_W'(1);
        else    return (ctr == '0)    ? ctr : ctr - CTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/pc_btb_unit_btb_array.sv
// btb_array
//   Direct-mapped BTB storage: valid/tag/target/direction-counter per entry.
//   Ports:
//     clk_i, rst_i        clock, async active-high reset (clears everything)
//     rd_pc_i             lookup PC; hit_o/taken_o/target_o are combinational
//                         and reflect the stored (pre-update) contents
//     wr_en_i             apply a resolved-branch update this edge
//     wr_pc_i, wr_taken_i, wr_target_i   update payload
//     flush_i             invalidate all entries; wins over wr_en_i
module btb_array
    import pc_btb_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 16,
    parameter int CTR_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rd_pc_i,
    output logic              hit_o,
    output logic              taken_o,
    output logic [ADDR_W-1:0] target_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_pc_i,
    input  logic              wr_taken_i,
    input  logic [ADDR_W-1:0] wr_target_i,
    input  logic              flush_i
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(weak_taken(CTR_W));

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][TAG_W-1:0]  tag_q,   tag_d;
    logic [DEPTH-1:0][ADDR_W-1:0] tgt_q,   tgt_d;
    logic [DEPTH-1:0][CTR_W-1:0]  ctr_q,   ctr_d;

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             wr_hit;

    assign rd_idx = rd_pc_i[IDX_W-1:0];
    assign rd_tag = rd_pc_i[ADDR_W-1:IDX_W];
    assign wr_idx = wr_pc_i[IDX_W-1:0];
    assign wr_tag = wr_pc_i[ADDR_W-1:IDX_W];

    assign hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign taken_o  = hit_o && ctr_q[rd_idx][CTR_W-1];
    assign target_o = hit_o ? tgt_q[rd_idx] : '0;

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (flush_i) begin
            // Only valid is cleared; stale tag/target/counter are masked by it.
            valid_d = '0;
        end else if (wr_en_i) begin
            if (wr_hit) begin
                ctr_d[wr_idx] = CTR_W'(sat_inc_dec(CTR_MAX_W'(ctr_q[wr_idx]), wr_taken_i, CTR_W));
                if (wr_taken_i) tgt_d[wr_idx] = wr_target_i;
            end else if (wr_taken_i) begin
                // Taken miss allocates, evicting whatever aliased into this slot.
                valid_d[wr_idx] = 1'b1;
                tag_d[wr_idx]   = wr_tag;
                tgt_d[wr_idx]   = wr_target_i;
                ctr_d[wr_idx]   = CTR_INIT;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            ctr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
        end
    end

endmodule

// File: rtl/pc_btb_unit.sv
// pc_btb_unit
//   IF-stage fetch PC register with direct-mapped BTB prediction.
//   Next PC priority: redirect > stall > predicted-taken > sequential.
//   Ports:
//     clk_i, rst_i            clock, async active-high reset
//     en_i                    global enable; all state holds when low
//     stall_i                 hold PC
//     redirect_i/_pc_i        recovery PC from EX (overrides stall)
//     upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i   resolved branch
//     flush_btb_i             invalidate all BTB entries
//     pc_o, pc_seq_o          fetch PC and pc+1 (wrapping)
//     pred_hit_o, pred_taken_o, pred_target_o   combinational lookup of pc_o
//     lookup_cnt_o            saturating count of en & !stall cycles
//     mispredict_cnt_o        saturating count of en & redirect cycles
module pc_btb_unit
    import pc_btb_unit_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                BTB_DEPTH  = 16,
    parameter int                CTR_W      = 2,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_ADDR_DEF),
    parameter int                PERF_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              flush_btb_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_seq_o,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    output logic [PERF_W-1:0] lookup_cnt_o,
    output logic [PERF_W-1:0] mispredict_cnt_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PERF_W-1:0] lookup_cnt_q, lookup_cnt_d;
    logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;

    btb_array #(
        .ADDR_W (ADDR_W),
        .DEPTH  (BTB_DEPTH),
        .CTR_W  (CTR_W)
    ) u_btb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_pc_i     (pc_q),
        .hit_o       (pred_hit_o),
        .taken_o     (pred_taken_o),
        .target_o    (pred_target_o),
        .wr_en_i     (en_i & upd_valid_i),
        .wr_pc_i     (upd_pc_i),
        .wr_taken_i  (upd_taken_i),
        .wr_target_i (upd_target_i),
        .flush_i     (en_i & flush_btb_i)
    );

    assign pc_o             = pc_q;
    assign pc_seq_o         = pc_q + ADDR_W'(1);
    assign lookup_cnt_o     = lookup_cnt_q;
    assign mispredict_cnt_o = mispred_cnt_q;

    always_comb begin
        pc_d          = pc_q;
        lookup_cnt_d  = lookup_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (en_i) begin
            if (redirect_i)        pc_d = redirect_pc_i;
            else if (stall_i)      pc_d = pc_q;
            else if (pred_taken_o) pc_d = pred_target_o;
            else                   pc_d = pc_seq_o;

            if (!stall_i && (lookup_cnt_q != '1))
                lookup_cnt_d = lookup_cnt_q + PERF_W'(1);
            if (redirect_i && (mispred_cnt_q != '1))
                mispred_cnt_d = mispred_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q          <= START_ADDR;
            lookup_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pc_q          <= pc_d;
            lookup_cnt_q  <= lookup_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_btb_unit.sv
// tb_pc_btb_unit
//   Directed bench for pc_btb_unit with a behavioural reference model.
//   The model keeps the BTB as plain int arrays and steps once per clock;
//   a negedge process compares every output to it, and literal checks
//   along the way pin the model to hand-computed values.
module tb_pc_btb_unit;

    localparam int AW    = 10;
    localparam int DEPTH = 16;
    localparam int CW    = 2;
    localparam int PW    = 32;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int PCMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, en, stall, redirect, upd_valid, upd_taken, flush;
    logic [AW-1:0] redirect_pc, upd_pc, upd_target;
    logic [AW-1:0] pc, pc_seq, pred_target;
    logic          pred_hit, pred_taken;
    logic [PW-1:0] lookup_cnt, mis_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pc_btb_unit #(
        .ADDR_W(AW), .BTB_DEPTH(DEPTH), .CTR_W(CW), .START_ADDR('0), .PERF_W(PW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .stall_i(stall),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .flush_btb_i(flush),
        .pc_o(pc), .pc_seq_o(pc_seq), .pred_hit_o(pred_hit),
        .pred_taken_o(pred_taken), .pred_target_o(pred_target),
        .lookup_cnt_o(lookup_cnt), .mispredict_cnt_o(mis_cnt)
    );

    // ---------------- reference model ----------------
    int     m_pc;
    bit     m_valid [DEPTH];
    int     m_tag   [DEPTH];
    int     m_tgt   [DEPTH];
    int     m_ctr   [DEPTH];
    longint m_look, m_mis;

    function automatic bit m_hit();
        int i = m_pc % DEPTH;
        return m_valid[i] && (m_tag[i] == m_pc / DEPTH);
    endfunction

    function automatic bit m_taken();
        return m_hit() && (m_ctr[m_pc % DEPTH] >= (CMAX + 1) / 2);
    endfunction

    function automatic int m_target();
        return m_hit() ? m_tgt[m_pc % DEPTH] : 0;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_look = 0; m_mis = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
    endtask

    task automatic model_step();
        int nxt, u, up;
        if (rst) begin
            model_reset();
            return;
        end
        if (!en) return;
        if (redirect)       nxt = int'(redirect_pc);
        else if (stall)     nxt = m_pc;
        else if (m_taken()) nxt = m_target();
        else                nxt = (m_pc + 1) % PCMOD;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        end else if (upd_valid) begin
            up = int'(upd_pc);
            u  = up % DEPTH;
            if (m_valid[u] && m_tag[u] == up / DEPTH) begin
                if (upd_taken) begin
                    m_ctr[u] = (m_ctr[u] == CMAX) ? CMAX : m_ctr[u] + 1;
                    m_tgt[u] = int'(upd_target);
                end else begin
                    m_ctr[u] = (m_ctr[u] == 0) ? 0 : m_ctr[u] - 1;
                end
            end else if (upd_taken) begin
                m_valid[u] = 1; m_tag[u] = up / DEPTH;
                m_tgt[u] = int'(upd_target); m_ctr[u] = (CMAX + 1) / 2;
            end
        end
        if (!stall && m_look < 64'hFFFF_FFFF) m_look++;
        if (redirect && m_mis < 64'hFFFF_FFFF) m_mis++;
        m_pc = nxt;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("pc",          64'(pc),          64'(m_pc));
        chk("pc_seq",      64'(pc_seq),      64'((m_pc + 1) % PCMOD));
        chk("pred_hit",    64'(pred_hit),    64'(m_hit()));
        chk("pred_taken",  64'(pred_taken),  64'(m_taken()));
        chk("pred_target", 64'(pred_target), 64'(m_target()));
        chk("lookup_cnt",  64'(lookup_cnt),  64'(m_look));
        chk("mispred_cnt", 64'(mis_cnt),     64'(m_mis));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic redir(input logic [AW-1:0] a);
        redirect = 1'b1; redirect_pc = a;
        tick();
        redirect = 1'b0;
    endtask

    task automatic upd(input logic [AW-1:0] a, input logic tk, input logic [AW-1:0] t);
        upd_valid = 1'b1; upd_pc = a; upd_taken = tk; upd_target = t;
        tick();
        upd_valid = 1'b0;
    endtask

    longint lk, mk;

    initial begin
        rst = 1'b1; en = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; flush = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b0;

        // 1. reset mid-run, then free-run
        tick(); tick(); tick();
        chk("run_pc3", 64'(pc), 64'd3);
        rst = 1'b1; model_reset();
        #1;
        chk("rst_pc",   64'(pc),         64'd0);
        chk("rst_hit",  64'(pred_hit),   64'd0);
        chk("rst_look", 64'(lookup_cnt), 64'd0);
        tick();
        rst = 1'b0;
        tick(); chk("free_pc1", 64'(pc), 64'd1);
        tick(); chk("free_pc2", 64'(pc), 64'd2);
        tick(); chk("free_pc3", 64'(pc), 64'd3);

        // 2. allocate at 5, predict taken to 0x40
        upd(10'd5, 1'b1, 10'h40);
        tick();
        chk("alloc_pc5",   64'(pc),          64'd5);
        chk("alloc_hit",   64'(pred_hit),    64'd1);
        chk("alloc_taken", 64'(pred_taken),  64'd1);
        chk("alloc_tgt",   64'(pred_target), 64'h40);
        tick();
        chk("alloc_jump",  64'(pc),          64'h40);

        // 3. saturation down then up
        upd(10'd5, 1'b0, 10'h40); upd(10'd5, 1'b0, 10'h40); upd(10'd5, 1'b0, 10'h40);
        redir(10'd5);
        chk("sat0_hit",   64'(pred_hit),   64'd1);
        chk("sat0_taken", 64'(pred_taken), 64'd0);
        tick();
        chk("sat0_seq",   64'(pc), 64'd6);
        for (int i = 0; i < 4; i++) upd(10'd5, 1'b1, 10'h40);
        redir(10'd5);
        chk("sat3_taken", 64'(pred_taken), 64'd1);
        upd(10'd5, 1'b0, 10'h40);           // 11 -> 10, lookup reads old
        chk("readold_jump", 64'(pc), 64'h40);
        redir(10'd5);
        chk("sat2_taken", 64'(pred_taken), 64'd1);
        upd(10'd5, 1'b0, 10'h40);           // 10 -> 01
        redir(10'd5);
        chk("sat1_taken", 64'(pred_taken), 64'd0);

        // 4. priority: redirect beats stall and prediction
        upd(10'd5, 1'b1, 10'h40);           // 01 -> 10
        redir(10'd5);
        chk("prio_pt", 64'(pred_taken), 64'd1);
        mk = m_mis;
        redirect = 1'b1; redirect_pc = 10'h100; stall = 1'b1;
        tick();
        redirect = 1'b0;
        chk("prio_pc",  64'(pc),      64'h100);
        chk("prio_mis", 64'(mis_cnt), 64'(mk + 1));
        lk = m_look;
        tick();
        stall = 1'b0;
        chk("stall_pc",   64'(pc),         64'h100);
        chk("stall_look", 64'(lookup_cnt), 64'(lk));

        // 5. alias, not-taken miss, flush beating update, read-old allocate
        upd(10'h15, 1'b1, 10'h80);
        redir(10'h05);
        chk("alias_miss", 64'(pred_hit), 64'd0);
        redir(10'h15);
        chk("alias_hit", 64'(pred_hit),    64'd1);
        chk("alias_tgt", 64'(pred_target), 64'h80);
        upd(10'd9, 1'b0, 10'h33);
        redir(10'd9);
        chk("nt_noalloc", 64'(pred_hit), 64'd0);
        flush = 1'b1;
        upd(10'd7, 1'b1, 10'h44);
        flush = 1'b0;
        redir(10'h15);
        chk("flush_15", 64'(pred_hit), 64'd0);
        redir(10'd7);
        chk("flush_7", 64'(pred_hit), 64'd0);
        redir(10'h0A);
        upd(10'h0A, 1'b1, 10'h50);
        chk("ro_seq", 64'(pc), 64'h0B);
        redir(10'h0A);
        chk("ro_hit", 64'(pred_hit),    64'd1);
        chk("ro_tgt", 64'(pred_target), 64'h50);

        // 6. wrap and enable
        redir(10'h3FF);
        chk("wrap_hit", 64'(pred_hit), 64'd0);
        chk("wrap_seq", 64'(pc_seq),   64'd0);
        tick();
        chk("wrap_pc",  64'(pc), 64'd0);
        lk = m_look; mk = m_mis;
        en = 1'b0;
        upd(10'd1, 1'b1, 10'h200);
        tick(); tick(); tick();
        chk("en0_pc",   64'(pc),         64'd0);
        chk("en0_look", 64'(lookup_cnt), 64'(lk));
        chk("en0_mis",  64'(mis_cnt),    64'(mk));
        en = 1'b1;
        redir(10'd1);
        chk("en0_btb",  64'(pred_hit), 64'd0);
        tick();

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
